// File: rtl/l1_dcache_ctrl_if.sv
// Request/response bundle between the Memory stage, the L1 data cache and the next-level memory.
// The controller takes the slave view; the core/memory side takes the master view.
interface l1_dcache_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req_valid;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [31:0]      rdata;
    logic             cache_hit;
    logic             cache_wait;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_ack;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        output rdata, cache_hit, cache_wait, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        input  rdata, cache_hit, cache_wait, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller, one word per line.
// Zero-latency hits in IDLE; misses walk WRITEBACK/REFILL/UPDATE against a req/ack next level.
module l1_dcache_ctrl #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 26,
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    l1_dcache_ctrl_if.slave bus
);
    localparam int unsigned     NUM_LINES = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_e;

    state_e state_q, state_d;

    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit_c, miss_c, victim_dirty_c;
    logic             line_we, valid_set, dirty_set, dirty_clr;
    logic [IDX_W-1:0] line_idx;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             unused_ok;

    assign req_idx        = bus.req_addr[IDX_W+1:2];
    assign req_tag        = bus.req_addr[31:IDX_W+2];
    assign unused_ok      = ^bus.req_addr[1:0];
    assign hit_c          = (state_q == IDLE) && bus.req_valid && valid_q[req_idx]
                            && (tag_q[req_idx] == req_tag);
    assign miss_c         = (state_q == IDLE) && bus.req_valid && !hit_c;
    assign victim_dirty_c = valid_q[req_idx] && dirty_q[req_idx];

    assign bus.cache_hit  = hit_c;
    assign bus.cache_wait = bus.req_valid && !hit_c;
    assign bus.rdata      = hit_c ? data_q[req_idx] : 32'h0;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss_c) state_d = victim_dirty_c ? WRITEBACK : REFILL;
            WRITEBACK: if (bus.mem_ack) state_d = REFILL;
            REFILL:    if (bus.mem_ack) state_d = UPDATE;
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Miss address is latched so a dropped or changed request cannot corrupt the fill.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        line_we     = 1'b0;
        valid_set   = 1'b0;
        dirty_set   = 1'b0;
        dirty_clr   = 1'b0;
        line_idx    = miss_idx_q;
        line_tag    = miss_tag_q;
        line_data   = bus.mem_rdata;

        if (hit_c && (hit_cnt_q != CNT_MAX)) hit_cnt_d = hit_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (hit_c && bus.req_we) begin
                    line_we   = 1'b1;
                    dirty_set = 1'b1;
                    line_idx  = req_idx;
                    line_tag  = req_tag;
                    line_data = bus.req_wdata;
                end
                if (miss_c) begin
                    miss_idx_d = req_idx;
                    miss_tag_d = req_tag;
                    mem_req_d  = 1'b1;
                    if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    if (victim_dirty_c) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[req_idx], req_idx, 2'b00};
                        mem_wdata_d = data_q[req_idx];
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {req_tag, req_idx, 2'b00};
                    end
                end
            end
            WRITEBACK: if (bus.mem_ack) begin
                dirty_clr  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = {miss_tag_q, miss_idx_q, 2'b00};
            end
            REFILL: if (bus.mem_ack) begin
                line_we   = 1'b1;
                valid_set = 1'b1;
                dirty_clr = 1'b1;
                mem_req_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (valid_set) valid_q[line_idx] <= 1'b1;
            if (dirty_set)      dirty_q[line_idx] <= 1'b1;
            else if (dirty_clr) dirty_q[line_idx] <= 1'b0;
        end
    end

    // Tag/data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= line_data;
        end
    end
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl: a table of single-cycle hit vectors plus hand-written miss,
// writeback, dropped-request, mid-transaction reset and counter-saturation sequences.
module tb_l1_dcache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    l1_dcache_ctrl_if #(.CNT_W(16)) bus ();

    l1_dcache_ctrl #(.IDX_W(4), .TAG_W(26), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        vld;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic        exp_wait;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid = vld;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    // Called at negedge+1; ack is seen by exactly one rising edge.
    task automatic ack(input logic [31:0] d);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
    endtask

    // Issues a missing request and serves it; returns on the IDLE cycle where the retry hits.
    task automatic do_miss(input string nm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic wb, input logic [31:0] wb_addr,
                           input logic [31:0] wb_data, input logic [31:0] fill);
        @(negedge clk);
        drive(1'b1, we, addr, wdata);
        #1;
        chk({nm, "_detect_wait"}, 32'(bus.cache_wait), 32'd1);
        chk({nm, "_detect_hit"},  32'(bus.cache_hit),  32'd0);
        @(negedge clk); #1;
        chk({nm, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        if (wb) begin
            chk({nm, "_wb_we"},    32'(bus.mem_we), 32'd1);
            chk({nm, "_wb_addr"},  bus.mem_addr,    wb_addr);
            chk({nm, "_wb_wdata"}, bus.mem_wdata,   wb_data);
            repeat (2) @(negedge clk);
            #1;
            chk({nm, "_wb_hold"}, 32'(bus.mem_req), 32'd1);
            ack(32'h0);
            chk({nm, "_rf_req"}, 32'(bus.mem_req), 32'd1);
        end
        chk({nm, "_rf_we"},   32'(bus.mem_we), 32'd0);
        chk({nm, "_rf_addr"}, bus.mem_addr,    addr & 32'hFFFF_FFFC);
        repeat (2) @(negedge clk);
        #1;
        chk({nm, "_rf_wait"}, 32'(bus.cache_wait), 32'd1);
        ack(fill);
        chk({nm, "_upd_req"},  32'(bus.mem_req),    32'd0);
        chk({nm, "_upd_wait"}, 32'(bus.cache_wait), 32'd1);
        @(negedge clk); #1;
        chk({nm, "_retry_hit"},   32'(bus.cache_hit),  32'd1);
        chk({nm, "_retry_wait"},  32'(bus.cache_wait), 32'd0);
        chk({nm, "_retry_rdata"}, bus.rdata,           fill);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h41, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h40, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h43, 32'h0,         1'b1, 1'b0, 32'h1234_5678};

        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mem_req",    32'(bus.mem_req),    32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_mem_addr",   bus.mem_addr,        32'h0);
        chk("rst_mem_wdata",  bus.mem_wdata,       32'h0);
        chk("rst_hit_count",  32'(bus.hit_count),  32'd0);
        chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
        chk("rst_wait",       32'(bus.cache_wait), 32'd0);

        // Cold load: refill only; the retried request counts as a hit.
        do_miss("cold", 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        chk("cold_miss_count", 32'(bus.miss_count), 32'd1);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d_hit", i),   32'(bus.cache_hit),  32'(vecs[i].exp_hit));
            chk($sformatf("vec%0d_wait", i),  32'(bus.cache_wait), 32'(vecs[i].exp_wait));
            chk($sformatf("vec%0d_rdata", i), bus.rdata,           vecs[i].exp_rdata);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("tbl_hit_count",  32'(bus.hit_count),  32'd6);
        chk("tbl_miss_count", 32'(bus.miss_count), 32'd1);

        // Conflict on index 0 with a dirty victim.
        do_miss("conf", 1'b0, 32'h440, 32'h0, 1'b1, 32'h40, 32'h1234_5678, 32'hCAFE_F00D);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("conf_hit_count",  32'(bus.hit_count),  32'd7);
        chk("conf_miss_count", 32'(bus.miss_count), 32'd2);

        // Store miss over a clean victim, then eviction of the stored word.
        do_miss("stm", 1'b1, 32'h80, 32'h55AA_55AA, 1'b0, 32'h0, 32'h0, 32'h0BAD_0BAD);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        chk("stm_load_hit",   32'(bus.cache_hit), 32'd1);
        chk("stm_load_rdata", bus.rdata,          32'h55AA_55AA);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        do_miss("evict", 1'b0, 32'hC0, 32'h0, 1'b1, 32'h80, 32'h55AA_55AA, 32'h1111_2222);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("evict_hit_count",  32'(bus.hit_count),  32'd10);
        chk("evict_miss_count", 32'(bus.miss_count), 32'd4);

        // Dropped request still fills the line; stray ack in IDLE is ignored.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h104, 32'h0);
        #1;
        chk("drop_wait_on", 32'(bus.cache_wait), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("drop_mem_req",  32'(bus.mem_req),    32'd1);
        chk("drop_mem_addr", bus.mem_addr,        32'h104);
        chk("drop_wait_off", 32'(bus.cache_wait), 32'd0);
        @(negedge clk); #1;
        ack(32'h7777_8888);
        chk("drop_fill_req", 32'(bus.mem_req), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        ack(32'hFFFF_FFFF);
        chk("idle_ack_req",  32'(bus.mem_req),    32'd0);
        chk("idle_ack_miss", 32'(bus.miss_count), 32'd5);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h104, 32'h0);
        #1;
        chk("drop_later_hit",   32'(bus.cache_hit), 32'd1);
        chk("drop_later_rdata", bus.rdata,          32'h7777_8888);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("drop_hit_count", 32'(bus.hit_count), 32'd11);

        // Reset while a writeback is outstanding.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hC0, 32'h9999_0000);
        #1;
        chk("rstwb_store_hit", 32'(bus.cache_hit), 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h1C0, 32'h0);
        #1;
        chk("rstwb_detect_wait", 32'(bus.cache_wait), 32'd1);
        @(negedge clk); #1;
        chk("rstwb_req",   32'(bus.mem_req), 32'd1);
        chk("rstwb_we",    32'(bus.mem_we),  32'd1);
        chk("rstwb_addr",  bus.mem_addr,     32'hC0);
        chk("rstwb_wdata", bus.mem_wdata,    32'h9999_0000);
        rst = 1'b1;
        #1;
        chk("rstwb_async_req",  32'(bus.mem_req),    32'd0);
        chk("rstwb_async_we",   32'(bus.mem_we),     32'd0);
        chk("rstwb_hit_count",  32'(bus.hit_count),  32'd0);
        chk("rstwb_miss_count", 32'(bus.miss_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        ack(32'h0);
        chk("rstwb_late_ack_req", 32'(bus.mem_req), 32'd0);
        do_miss("postrst", 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5);
        chk("postrst_miss_count", 32'(bus.miss_count), 32'd1);

        // Hold the hitting load until the hit counter saturates.
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_fffe", 32'(bus.hit_count), 32'h0000_FFFE);
        @(negedge clk); #1;
        chk("sat_ffff", 32'(bus.hit_count), 32'h0000_FFFF);
        @(negedge clk); #1;
        chk("sat_hold",     32'(bus.hit_count),  32'h0000_FFFF);
        chk("sat_still_hit", 32'(bus.cache_hit), 32'd1);
        chk("sat_miss_count", 32'(bus.miss_count), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l1_dcache_ctrl.md
Name: l1_dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits directly downstream of the Memory stage and services its load/store requests.
- Produces the CacheWait stall consumed by the hazard unit.
- Backs onto a next-level memory (L2 or main memory) through a req/ack handshake.
- One word per line; word-aligned addressing; byte offset bits [1:0] ignored.

Parameters:
- IDX_W, 4, index width; NUM_LINES = 2**IDX_W = 16.
- TAG_W, 26, tag width = 32 - 2 - IDX_W.
- CNT_W, 16, width of hit/miss performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  Memory stage has a load/store this cycle (MemwriteM or load ResultSrcM).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  ALUResultM.
- req_wdata  in  32  WriteDataM.
- rdata  out  32  load data; valid when cache_hit=1.
- cache_hit  out  1  current request hits in IDLE.
- cache_wait  out  1  stall request to the hazard unit.
- mem_req  out  1  next-level request; registered.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  32  word address {tag,index,2'b00}.
- mem_wdata  out  32  victim data.
- mem_rdata  in  32  refill data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W], data[32].
- Address split: index = req_addr[IDX_W+1:2]; tag = req_addr[31:IDX_W+2].
- Reset: all valid/dirty = 0; state = IDLE; mem_req = mem_we = 0; mem_addr = mem_wdata = 0; both counters = 0. Data and tag arrays need no reset.
- Reset asserted mid-transaction abandons the transaction immediately. mem_req falls asynchronously; a late mem_ack is ignored.
- cache_hit = (state==IDLE) & req_valid & valid[index] & (tag[index]==tag).
- rdata = data[index] combinationally (zero-latency hit); 0 when cache_hit = 0.
- cache_wait = req_valid & ~cache_hit, combinational. It is 1 in every non-IDLE state while req_valid = 1.
- FSM states: IDLE, WRITEBACK, REFILL, UPDATE.
- IDLE:
  - Store hit: data <= req_wdata and dirty <= 1 at the clock edge.
  - Load hit: no state change.
  - Miss with victim valid & dirty: register mem_req=1, mem_we=1, mem_addr={victim tag,index,00}, mem_wdata=victim data; go to WRITEBACK.
  - Miss otherwise: register mem_req=1, mem_we=0, mem_addr={tag,index,00}; go to REFILL.
  - Counters increment once per request: hit_count on a hit; miss_count on the IDLE→miss transition only, never again while waiting.
- WRITEBACK: hold mem_req/mem_we/mem_addr/mem_wdata until mem_ack. On ack: clear dirty, issue the refill read (mem_req stays 1, mem_we=0, mem_addr = requested address), go to REFILL.
- REFILL: hold until mem_ack. On ack: line <= {valid=1, dirty=0, tag, mem_rdata}, mem_req <= 0, go to UPDATE.
- UPDATE: one bubble cycle, then IDLE. The retried request then hits. A store hit then writes and sets dirty (write-allocate).
- Miss latency: 1 (detect) + memory cycles + 1 (UPDATE); the hit is seen on the following IDLE cycle.
- Dropped request: if req_valid falls outside IDLE, the current transaction still completes and the line is filled.
- mem_ack in IDLE or UPDATE is ignored.
- Counters saturate at all-ones and never wrap.
- Requester contract: req_addr/req_we/req_wdata must be held stable while cache_wait = 1 (guaranteed by the stall).

Test Plan:
- Cold load 0x0000_0040, memory returns 0xDEAD_BEEF after 3 cycles -> mem_req=1, mem_we=0, mem_addr=0x40; cache_wait high until refill plus UPDATE; then cache_hit=1, rdata=0xDEAD_BEEF, miss_count=1.
- Repeat load 0x40 -> cache_hit=1 same cycle, cache_wait=0, no mem_req, hit_count=1.
- Store 0x1234_5678 to 0x40 (hit), then load 0x440 (same index 0, different tag) -> writeback with mem_we=1, mem_addr=0x40, mem_wdata=0x1234_5678; then refill read at mem_addr=0x440.
- Store miss to 0x80 with clean victim -> refill only, then write; line dirty with new data; later eviction writes back the stored value.
- Assert rst while in WRITEBACK -> mem_req=0 immediately; state IDLE; all lines invalid; a subsequent load to 0x40 misses.
- Force 65535 hits, then one more -> hit_count stays 0xFFFF.
